relay_mode_ctrl: RTL and testbench



---
 rtl/relay_mode_ctrl_pkg.sv | 48 ++++
 rtl/relay_mode_ctrl_if.sv | 34 +++
 rtl/relay_bit_strobe.sv | 39 +++
 rtl/relay_mode_ctrl.sv | 131 +++++++++++++
 tb/tb_relay_mode_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relay_mode_ctrl_pkg.sv
// Shared mode codes, frame delimiters and FSM encoding for the relay front-end
// mode sequencer.
package relay_mode_ctrl_pkg;

  localparam logic [2:0] ModSniffer      = 3'b000;
  localparam logic [2:0] ModTagsimListen = 3'b001;
  localparam logic [2:0] ModTagsimMod    = 3'b010;
  localparam logic [2:0] ModReaderListen = 3'b011;
  localparam logic [2:0] ModReaderMod    = 3'b100;
  localparam logic [2:0] ModFakeReader   = 3'b101;
  localparam logic [2:0] ModFakeTag      = 3'b110;

  localparam logic [19:0] ReaderSof     = 20'h0000c;
  localparam logic [19:0] TagSof        = 20'h000f0;
  localparam logic [19:0] ReaderEofZero = 20'h00000;
  localparam logic [19:0] ReaderEofTail = 20'hc0000;

  typedef enum logic [1:0] {
    StIdle,
    StListen,
    StMod
  } state_e;

  function automatic logic is_fake(input logic [2:0] mode);
    return (mode == ModFakeReader) || (mode == ModFakeTag);
  endfunction

  function automatic logic [2:0] listen_mode(input logic reader);
    return reader ? ModReaderListen : ModTagsimListen;
  endfunction

  function automatic logic [2:0] mod_mode(input logic reader);
    return reader ? ModReaderMod : ModTagsimMod;
  endfunction

  function automatic logic sof_match(input logic reader, input logic [19:0] shift);
    return reader ? (shift == ReaderSof) : (shift == TagSof);
  endfunction

  // Tag frames end on any 12-bit silent run; reader frames need the full window.
  function automatic logic eof_match(input logic reader, input logic [19:0] shift);
    if (reader) begin
      return (shift == ReaderEofZero) || (shift == ReaderEofTail);
    end
    return shift[11:0] == 12'h000;
  endfunction

endpackage

// File: rtl/relay_mode_ctrl_if.sv
// Mode request, relay bit stream and frame status between the relay decoder,
// the mode sequencer and the modulation consumers.
interface relay_mode_ctrl_if;
  logic [2:0] hi_simulate_mod_type;
  logic       bit_in;
  logic [2:0] mod_type;
  logic       data_out;
  logic       frame_active;
  logic [9:0] frame_bits;
  logic       frame_done;
  logic       timeout;

  modport master (
    output hi_simulate_mod_type,
    output bit_in,
    input  mod_type,
    input  data_out,
    input  frame_active,
    input  frame_bits,
    input  frame_done,
    input  timeout
  );

  modport slave (
    input  hi_simulate_mod_type,
    input  bit_in,
    output mod_type,
    output data_out,
    output frame_active,
    output frame_bits,
    output frame_done,
    output timeout
  );
endinterface

// File: rtl/relay_bit_strobe.sv
// Relay bit-rate prescaler: one strobe per BitDiv clocks, mid-bit, while enabled.
module relay_bit_strobe #(
  parameter int unsigned BitDiv = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int unsigned CntW = (BitDiv > 1) ? $clog2(BitDiv) : 1;
  localparam logic [CntW-1:0] Half = CntW'(BitDiv / 2);
  localparam logic [CntW-1:0] Last = CntW'(BitDiv - 1);

  logic [CntW-1:0] prescaler_q, prescaler_d;

  always_comb begin
    prescaler_d = prescaler_q;
    if (clr || !en) begin
      prescaler_d = '0;
    end else if (prescaler_q == Last) begin
      prescaler_d = '0;
    end else begin
      prescaler_d = prescaler_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

  assign strobe = en && !clr && (prescaler_q == Half);

endmodule

// File: rtl/relay_mode_ctrl.sv
// Chooses the analog modulation mode in fake-reader / fake-tag relay operation by
// tracking start/end-of-frame patterns in the decoded relay bit stream.
module relay_mode_ctrl
  import relay_mode_ctrl_pkg::*;
#(
  parameter int unsigned BIT_DIV        = 16,
  parameter int unsigned MAX_FRAME_BITS = 1023
) (
  input  logic              clk,
  input  logic              reset,
  relay_mode_ctrl_if.slave  bus
);

  localparam logic [9:0] MaxBits = 10'(MAX_FRAME_BITS);

  state_e      state_q;
  logic [2:0]  mode_q;
  logic [19:0] shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  frame_bits_q, frame_bits_inc;
  logic [2:0]  mod_type_q;
  logic        frame_done_q, timeout_q;

  logic fake, reader, mode_change, strobe;
  logic sof_hit, eof_hit, limit_hit;

  assign fake   = is_fake(bus.hi_simulate_mod_type);
  assign reader = (bus.hi_simulate_mod_type == ModFakeReader);
  // Any request change while active forces a clean restart through IDLE.
  assign mode_change = (state_q != StIdle) && (bus.hi_simulate_mod_type != mode_q);

  relay_bit_strobe #(
    .BitDiv (BIT_DIV)
  ) u_bit_strobe (
    .clk    (clk),
    .reset  (reset),
    .en     (fake),
    .clr    (mode_change),
    .strobe (strobe)
  );

  // Pattern checks look at the post-shift window so the mode follows the
  // completing bit on the same edge.
  always_comb begin
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    frame_bits_inc = (frame_bits_q == 10'h3ff) ? frame_bits_q : frame_bits_q + 10'd1;
    if (strobe) begin
      shift_d   = {shift_q[18:0], bus.bit_in};
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
    sof_hit   = strobe && sof_match(reader, shift_d);
    eof_hit   = strobe && (bit_cnt_d == 3'd0) && eof_match(reader, shift_d);
    limit_hit = strobe && (frame_bits_inc == MaxBits);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      mode_q       <= ModSniffer;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_bits_q <= '0;
      mod_type_q   <= ModSniffer;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
      mode_q       <= bus.hi_simulate_mod_type;
      if (mode_change) begin
        state_q    <= StIdle;
        mod_type_q <= ModSniffer;
        shift_q    <= '0;
        bit_cnt_q  <= '0;
      end else begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_d;
        unique case (state_q)
          StIdle: begin
            if (fake) begin
              state_q    <= StListen;
              mod_type_q <= listen_mode(reader);
            end else begin
              mod_type_q <= ModSniffer;
            end
          end
          StListen: begin
            if (sof_hit) begin
              state_q      <= StMod;
              mod_type_q   <= mod_mode(reader);
              bit_cnt_q    <= '0;
              frame_bits_q <= '0;
            end else begin
              mod_type_q <= listen_mode(reader);
            end
          end
          StMod: begin
            if (strobe) begin
              frame_bits_q <= frame_bits_inc;
            end
            // A frame that ends cleanly on its last permitted bit is not a timeout.
            if (eof_hit) begin
              state_q      <= StListen;
              mod_type_q   <= listen_mode(reader);
              frame_done_q <= 1'b1;
            end else if (limit_hit) begin
              state_q    <= StListen;
              mod_type_q <= listen_mode(reader);
              timeout_q  <= 1'b1;
            end else begin
              mod_type_q <= mod_mode(reader);
            end
          end
          default: begin
            state_q    <= StIdle;
            mod_type_q <= ModSniffer;
          end
        endcase
      end
    end
  end

  assign bus.mod_type     = mod_type_q;
  assign bus.data_out     = shift_q[3];
  assign bus.frame_active = (state_q == StMod);
  assign bus.frame_bits   = frame_bits_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_relay_mode_ctrl.sv
// Self-checking bench for relay_mode_ctrl (frame limit shortened to 32 bits).
module tb_relay_mode_ctrl;
  import relay_mode_ctrl_pkg::*;

  localparam int BitDiv = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  int done_acc = 0;
  int to_acc = 0;

  relay_mode_ctrl_if bus ();

  relay_mode_ctrl #(
    .BIT_DIV        (BitDiv),
    .MAX_FRAME_BITS (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reset, select a mode, release on a negedge; returns just after the IDLE->LISTEN edge.
  task automatic start(input logic [2:0] mode);
    reset = 1'b0;
    bus.hi_simulate_mod_type = mode;
    bus.bit_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One relay bit period; contains exactly one strobe edge. Pulses are accumulated.
  task automatic send_bit(input logic b);
    bus.bit_in = b;
    repeat (BitDiv) begin
      @(posedge clk);
      @(negedge clk);
      done_acc += int'(bus.frame_done);
      to_acc   += int'(bus.timeout);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.hi_simulate_mod_type = ModFakeReader;
    bus.bit_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mod_type, bus.frame_active, bus.frame_done, bus.timeout, bus.data_out} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {bus.mod_type, bus.frame_active,
               bus.frame_done, bus.timeout, bus.data_out});
    end
    checks++;
    if (bus.frame_bits !== 10'd0) begin
      errors++;
      $display("FAIL reset_frame_bits got %0d want 0", bus.frame_bits);
    end
    start(ModFakeReader);
    send_bits(32'hc, 4);
    send_bits(32'h0, 2);
    checks++;
    if (bus.frame_active !== 1'b1 || bus.frame_bits !== 10'd2) begin
      errors++;
      $display("FAIL pre_reset_mod got active=%b bits=%0d want 1/2", bus.frame_active,
               bus.frame_bits);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bus.mod_type !== ModSniffer || bus.frame_active !== 1'b0 || bus.frame_bits !== 10'd0) begin
      errors++;
      $display("FAIL async_reset got mod=%0d active=%b bits=%0d want 0/0/0", bus.mod_type,
               bus.frame_active, bus.frame_bits);
    end
  endtask

  task automatic test_reader_frame;
    start(ModFakeReader);
    checks++;
    if (bus.mod_type !== ModReaderListen) begin
      errors++;
      $display("FAIL reader_listen got %0d want %0d", bus.mod_type, ModReaderListen);
    end
    send_bits(32'hc, 4);
    checks++;
    if (bus.mod_type !== ModReaderMod || bus.frame_active !== 1'b1 || bus.frame_bits !== 10'd0) begin
      errors++;
      $display("FAIL reader_sof got mod=%0d active=%b bits=%0d want 4/1/0", bus.mod_type,
               bus.frame_active, bus.frame_bits);
    end
    done_acc = 0;
    send_bits(32'h0, 8);
    checks++;
    if (bus.mod_type !== ModReaderMod || bus.frame_bits !== 10'd8 || done_acc != 0) begin
      errors++;
      $display("FAIL reader_8_zero got mod=%0d bits=%0d done=%0d want 4/8/0", bus.mod_type,
               bus.frame_bits, done_acc);
    end
    send_bits(32'h0, 7);
    checks++;
    if (bus.mod_type !== ModReaderMod || bus.frame_bits !== 10'd15) begin
      errors++;
      $display("FAIL reader_15 got mod=%0d bits=%0d want 4/15", bus.mod_type, bus.frame_bits);
    end
    done_acc = 0;
    to_acc = 0;
    send_bit(1'b0);
    checks++;
    if (bus.mod_type !== ModReaderListen || bus.frame_active !== 1'b0 || done_acc != 1 ||
        to_acc != 0 || bus.frame_bits !== 10'd16) begin
      errors++;
      $display("FAIL reader_eof got mod=%0d active=%b done=%0d to=%0d bits=%0d want 3/0/1/0/16",
               bus.mod_type, bus.frame_active, done_acc, to_acc, bus.frame_bits);
    end
    done_acc = 0;
    send_bits(32'h0, 8);
    checks++;
    if (bus.mod_type !== ModReaderListen || done_acc != 0 || bus.frame_bits !== 10'd16) begin
      errors++;
      $display("FAIL listen_ignores_eof got mod=%0d done=%0d bits=%0d want 3/0/16",
               bus.mod_type, done_acc, bus.frame_bits);
    end
  endtask

  task automatic test_tag_frame;
    start(ModFakeTag);
    checks++;
    if (bus.mod_type !== ModTagsimListen) begin
      errors++;
      $display("FAIL tag_listen got %0d want %0d", bus.mod_type, ModTagsimListen);
    end
    send_bits(32'hf0, 8);
    checks++;
    if (bus.mod_type !== ModTagsimMod) begin
      errors++;
      $display("FAIL tag_sof got %0d want %0d", bus.mod_type, ModTagsimMod);
    end
    done_acc = 0;
    send_bits(32'h5a, 8);
    send_bits(32'h00, 8);
    checks++;
    if (bus.mod_type !== ModTagsimMod || bus.frame_bits !== 10'd16 || done_acc != 0) begin
      errors++;
      $display("FAIL tag_16 got mod=%0d bits=%0d done=%0d want 2/16/0", bus.mod_type,
               bus.frame_bits, done_acc);
    end
    // Bits 19 and 20 complete a 12-bit zero window off byte alignment.
    send_bits(32'h0, 4);
    checks++;
    if (bus.mod_type !== ModTagsimMod || bus.frame_bits !== 10'd20 || done_acc != 0) begin
      errors++;
      $display("FAIL tag_unaligned got mod=%0d bits=%0d done=%0d want 2/20/0", bus.mod_type,
               bus.frame_bits, done_acc);
    end
    send_bits(32'h0, 4);
    checks++;
    if (bus.mod_type !== ModTagsimListen || bus.frame_bits !== 10'd24 || done_acc != 1) begin
      errors++;
      $display("FAIL tag_eof got mod=%0d bits=%0d done=%0d want 1/24/1", bus.mod_type,
               bus.frame_bits, done_acc);
    end
  endtask

  task automatic test_timeout;
    start(ModFakeReader);
    send_bits(32'hc, 4);
    done_acc = 0;
    to_acc = 0;
    send_bits(32'h7fffffff, 31);
    checks++;
    if (bus.mod_type !== ModReaderMod || to_acc != 0 || bus.frame_bits !== 10'd31) begin
      errors++;
      $display("FAIL timeout_31 got mod=%0d to=%0d bits=%0d want 4/0/31", bus.mod_type,
               to_acc, bus.frame_bits);
    end
    send_bit(1'b1);
    checks++;
    if (bus.mod_type !== ModReaderListen || to_acc != 1 || done_acc != 0 ||
        bus.frame_bits !== 10'd32) begin
      errors++;
      $display("FAIL timeout_32 got mod=%0d to=%0d done=%0d bits=%0d want 3/1/0/32",
               bus.mod_type, to_acc, done_acc, bus.frame_bits);
    end
    start(ModFakeReader);
    send_bits(32'hc, 4);
    done_acc = 0;
    to_acc = 0;
    send_bits(32'hfff, 12);
    send_bits(32'h0, 19);
    checks++;
    if (bus.mod_type !== ModReaderMod || done_acc != 0 || to_acc != 0) begin
      errors++;
      $display("FAIL eof_limit_31 got mod=%0d done=%0d to=%0d want 4/0/0", bus.mod_type,
               done_acc, to_acc);
    end
    send_bit(1'b0);
    checks++;
    if (bus.mod_type !== ModReaderListen || done_acc != 1 || to_acc != 0 ||
        bus.frame_bits !== 10'd32) begin
      errors++;
      $display("FAIL eof_beats_timeout got mod=%0d done=%0d to=%0d bits=%0d want 3/1/0/32",
               bus.mod_type, done_acc, to_acc, bus.frame_bits);
    end
  endtask

  task automatic test_mode_switch;
    start(ModFakeReader);
    send_bits(32'hc, 4);
    send_bits(32'h0, 3);
    bus.hi_simulate_mod_type = ModSniffer;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mod_type !== ModSniffer || bus.frame_active !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL switch_sniffer got mod=%0d active=%b done=%b to=%b want 0/0/0/0",
               bus.mod_type, bus.frame_active, bus.frame_done, bus.timeout);
    end
    repeat (3) @(negedge clk);
    bus.hi_simulate_mod_type = ModFakeTag;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mod_type !== ModTagsimListen) begin
      errors++;
      $display("FAIL back_to_tag got %0d want %0d", bus.mod_type, ModTagsimListen);
    end
    bus.hi_simulate_mod_type = ModFakeReader;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mod_type !== ModSniffer) begin
      errors++;
      $display("FAIL tag_to_reader_idle got %0d want 0", bus.mod_type);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.mod_type !== ModReaderListen) begin
      errors++;
      $display("FAIL tag_to_reader_listen got %0d want %0d", bus.mod_type, ModReaderListen);
    end
    // A fresh SOF only matches if the shift window and bit timing were cleared.
    send_bits(32'hc, 4);
    checks++;
    if (bus.mod_type !== ModReaderMod) begin
      errors++;
      $display("FAIL resync_sof got %0d want %0d", bus.mod_type, ModReaderMod);
    end
  endtask

  task automatic test_data_out;
    logic exp_q[$];
    logic b, exp_bit;
    start(ModFakeReader);
    exp_q = {1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 40; i++) begin
      b = 1'($urandom_range(0, 1));
      exp_q.push_back(b);
      send_bit(b);
      exp_bit = exp_q.pop_front();
      checks++;
      if (bus.data_out !== exp_bit) begin
        errors++;
        $display("FAIL data_out_%0d got %b want %b", i, bus.data_out, exp_bit);
      end
    end
  endtask

  initial begin
    bus.hi_simulate_mod_type = ModSniffer;
    bus.bit_in = 1'b0;
    test_reset();
    test_reader_frame();
    test_tag_frame();
    test_timeout();
    test_mode_switch();
    test_data_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
